// File: rtl/intr_entry_seq_if.sv
// Interrupt-entry sequencer bus: core-side status in, fetch/stack/memory controls out.
interface intr_entry_seq_if;
    logic       intr_req;
    logic       pipe_busy;
    logic [7:0] next_pc;
    logic [7:0] sp_in;
    logic [7:0] mem_rdata;
    logic       rti_done;

    logic       freeze;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       sp_we;
    logic [7:0] sp_next;
    logic       intr_ack;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       in_service;

    // Sequencer side
    modport master (
        input  intr_req, pipe_busy, next_pc, sp_in, mem_rdata, rti_done,
        output freeze, mem_we, mem_re, mem_addr, mem_wdata, sp_we, sp_next,
               intr_ack, redirect, redirect_pc, in_service
    );

    // Core side (fetch/PC unit, EX stage, data memory)
    modport slave (
        output intr_req, pipe_busy, next_pc, sp_in, mem_rdata, rti_done,
        input  freeze, mem_we, mem_re, mem_addr, mem_wdata, sp_we, sp_next,
               intr_ack, redirect, redirect_pc, in_service
    );
endinterface

// File: rtl/intr_entry_seq.sv
// Interrupt-entry sequencer: freezes fetch, drains the pipe, pushes the resume PC,
// reads the vector slot and redirects the PC into the handler.
module intr_entry_seq #(
    parameter logic [7:0] VEC_ADDR = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    intr_entry_seq_if.master bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_PUSH     = 3'd2;
    localparam logic [2:0] ST_VEC_RD   = 3'd3;
    localparam logic [2:0] ST_VEC_WAIT = 3'd4;
    localparam logic [2:0] ST_SERVICE  = 3'd5;

    logic [2:0] state_q, state_d;
    logic       req_q;
    logic       pending_q, pending_d;
    logic [7:0] ret_pc_q, ret_pc_d;
    logic       req_rise;

    assign req_rise = bus.intr_req & ~req_q;

    // A new edge always latches a request (even during PUSH); PUSH consumes the current one.
    always_comb begin
        pending_d = pending_q;
        if (req_rise) begin
            pending_d = 1'b1;
        end else if (state_q == ST_PUSH) begin
            pending_d = 1'b0;
        end
    end

    // Entry sequence: wait for the pipe to drain, then push, vector read, redirect, service.
    always_comb begin
        state_d  = state_q;
        ret_pc_d = ret_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.pipe_busy) begin
                    ret_pc_d = bus.next_pc;
                    state_d  = ST_PUSH;
                end
            end
            ST_PUSH:     state_d = ST_VEC_RD;
            ST_VEC_RD:   state_d = ST_VEC_WAIT;
            ST_VEC_WAIT: state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (bus.rti_done) begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // State, edge-detect and captured resume PC; reset abandons any half-done entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            ret_pc_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            req_q     <= bus.intr_req;
            pending_q <= pending_d;
            ret_pc_q  <= ret_pc_d;
        end
    end

    // Moore output decode; data buses stay at zero whenever their strobe is idle.
    always_comb begin
        bus.freeze      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_re      = 1'b0;
        bus.mem_addr    = 8'h00;
        bus.mem_wdata   = 8'h00;
        bus.sp_we       = 1'b0;
        bus.sp_next     = 8'h00;
        bus.intr_ack    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.in_service  = 1'b0;
        case (state_q)
            ST_DRAIN: begin
                bus.freeze = 1'b1;
            end
            ST_PUSH: begin
                bus.freeze    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.sp_in;
                bus.mem_wdata = ret_pc_q;
                bus.sp_we     = 1'b1;
                bus.sp_next   = bus.sp_in - 8'd1;
                bus.intr_ack  = 1'b1;
            end
            ST_VEC_RD: begin
                bus.freeze   = 1'b1;
                bus.mem_re   = 1'b1;
                bus.mem_addr = VEC_ADDR;
            end
            ST_VEC_WAIT: begin
                bus.freeze      = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = bus.mem_rdata;
            end
            ST_SERVICE: begin
                bus.in_service = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intr_entry_seq.sv
// Bench for intr_entry_seq: directed entry scenarios followed by random traffic,
// every cycle compared against a timeline model of interrupt entry.
module tb_intr_entry_seq;

    localparam logic [7:0] VEC = 8'h01;

    logic clk = 1'b0;
    logic reset;

    intr_entry_seq_if bus();

    intr_entry_seq #(.VEC_ADDR(VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       rst, req, busy, rti;
    logic [7:0] npc, sp, rdata;

    // Model: position in the entry timeline (0 none, 1 draining, 2 push, 3 vector read,
    // 4 redirect, 5 handler running), the one-deep request latch and the saved PC.
    int         mPos;
    bit         mPend;
    bit         mReqPrev;
    logic [7:0] mRetPc;

    int         cyc;
    bit         checkEn;
    bit         prevFreeze;

    int         weCount, reCount, ackCount, redirCount, freezeCount, freezeRises;
    int         weCyc, redirCyc, svcCyc, freezeRiseCyc;
    logic [7:0] lastWAddr, lastWData, lastSpNext, lastRpc;

    int edgeCyc, rtiCyc;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] expectBundle(input int pos, input logic [7:0] spv,
                                                 input logic [7:0] rd, input logic [7:0] pc);
        logic [38:0] b;
        b = '0;
        case (pos)
            1: b = {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
            2: b = {1'b1, 1'b1, 1'b0, spv, pc, 1'b1, 8'((int'(spv) + 255) % 256),
                    1'b1, 1'b0, 8'h00, 1'b0};
            3: b = {1'b1, 1'b0, 1'b1, VEC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
            4: b = {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, rd, 1'b0};
            5: b = {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
            default: b = '0;
        endcase
        return b;
    endfunction

    task automatic clearTally();
        weCount = 0; reCount = 0; ackCount = 0; redirCount = 0;
        freezeCount = 0; freezeRises = 0;
        weCyc = -1; redirCyc = -1; svcCyc = -1; freezeRiseCyc = -1;
        lastWAddr = 8'h00; lastWData = 8'h00; lastSpNext = 8'h00; lastRpc = 8'h00;
    endtask

    // Drive the current input set for one clock, compare at the falling edge,
    // then advance the model on the rising edge with the same inputs.
    task automatic applyStimulus();
        logic [38:0] obs;
        int          oldPos;
        bit          rise;
        reset         = rst;
        bus.intr_req  = req;
        bus.pipe_busy = busy;
        bus.next_pc   = npc;
        bus.sp_in     = sp;
        bus.mem_rdata = rdata;
        bus.rti_done  = rti;
        @(negedge clk);
        obs = {bus.freeze, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.sp_we,
               bus.sp_next, bus.intr_ack, bus.redirect, bus.redirect_pc, bus.in_service};
        if (checkEn) begin
            checkOutput("outputs", 64'(obs), 64'(expectBundle(mPos, sp, rdata, mRetPc)));
        end
        if (bus.mem_we === 1'b1) begin
            weCount++; weCyc = cyc; lastWAddr = bus.mem_addr; lastWData = bus.mem_wdata;
            lastSpNext = bus.sp_next;
        end
        if (bus.mem_re === 1'b1) reCount++;
        if (bus.intr_ack === 1'b1) ackCount++;
        if (bus.redirect === 1'b1) begin
            redirCount++; redirCyc = cyc; lastRpc = bus.redirect_pc;
        end
        if (bus.in_service === 1'b1 && svcCyc < 0) svcCyc = cyc;
        if (bus.freeze === 1'b1) begin
            freezeCount++;
            if (!prevFreeze) begin
                freezeRises++;
                if (freezeRiseCyc < 0) freezeRiseCyc = cyc;
            end
        end
        prevFreeze = (bus.freeze === 1'b1);
        @(posedge clk);
        if (rst) begin
            mPos = 0; mPend = 0; mReqPrev = 0; mRetPc = 8'h00;
        end else begin
            rise     = req && !mReqPrev;
            mReqPrev = req;
            oldPos   = mPos;
            if (mPos == 0) begin
                if (mPend) mPos = 1;
            end else if (mPos == 1) begin
                if (!busy) begin
                    mRetPc = npc;
                    mPos   = 2;
                end
            end else if (mPos == 5) begin
                if (rti) mPos = 0;
            end else begin
                mPos = mPos + 1;
            end
            if (rise) mPend = 1;
            else if (oldPos == 2) mPend = 0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        cyc = 0; checkEn = 0; prevFreeze = 0;
        mPos = 0; mPend = 0; mReqPrev = 0; mRetPc = 8'h00;
        edgeCyc = 0; rtiCyc = 0;
        clearTally();
        rst = 1; req = 0; busy = 0; rti = 0; npc = 8'h23; sp = 8'hFF; rdata = 8'h40;

        // Reset state
        applyStimulus();
        checkEn = 1;
        applyStimulus();
        rst = 0;
        repeat (3) applyStimulus();

        // Basic entry
        $display("[TB] basic entry");
        clearTally();
        req = 1; applyStimulus(); edgeCyc = cyc;
        repeat (7) applyStimulus();
        rti = 1; applyStimulus(); rti = 0; req = 0;
        repeat (3) applyStimulus();
        checkOutput("basic_we_count", 64'(weCount), 64'd1);
        checkOutput("basic_ack_count", 64'(ackCount), 64'd1);
        checkOutput("basic_push_addr", 64'(lastWAddr), 64'hFF);
        checkOutput("basic_push_data", 64'(lastWData), 64'h23);
        checkOutput("basic_sp_next", 64'(lastSpNext), 64'hFE);
        checkOutput("basic_redirect_pc", 64'(lastRpc), 64'h40);
        checkOutput("basic_redirect_lat", 64'(redirCyc - edgeCyc), 64'd4);
        checkOutput("basic_service_lat", 64'(svcCyc - edgeCyc), 64'd5);

        // Drain stall
        $display("[TB] drain stall");
        clearTally();
        npc = 8'h10;
        req = 1; applyStimulus(); edgeCyc = cyc;
        applyStimulus();
        busy = 1; npc = 8'h10; applyStimulus();
        npc = 8'h11; applyStimulus();
        npc = 8'h12; applyStimulus();
        busy = 0; npc = 8'h13; applyStimulus();
        repeat (5) applyStimulus();
        rti = 1; applyStimulus(); rti = 0; req = 0;
        repeat (2) applyStimulus();
        checkOutput("stall_push_data", 64'(lastWData), 64'h13);
        checkOutput("stall_push_lat", 64'(weCyc - edgeCyc), 64'd5);
        checkOutput("stall_freeze_cycles", 64'(freezeCount), 64'd7);

        // Stack pointer wrap
        $display("[TB] sp wrap");
        clearTally();
        sp = 8'h00; npc = 8'h55; rdata = 8'h9A;
        req = 1; applyStimulus();
        repeat (7) applyStimulus();
        rti = 1; applyStimulus(); rti = 0; req = 0;
        repeat (2) applyStimulus();
        checkOutput("wrap_push_addr", 64'(lastWAddr), 64'h00);
        checkOutput("wrap_sp_next", 64'(lastSpNext), 64'hFF);
        checkOutput("wrap_redirect_pc", 64'(lastRpc), 64'h9A);

        // Request arriving while in service
        $display("[TB] request in service");
        sp = 8'hF0; npc = 8'h31; rdata = 8'h60;
        req = 1; applyStimulus();
        repeat (6) applyStimulus();
        req = 0; repeat (2) applyStimulus();
        clearTally();
        req = 1; repeat (4) applyStimulus();
        checkOutput("svc_no_strobes", 64'(weCount + reCount + ackCount + redirCount + freezeCount), 64'd0);
        rtiCyc = cyc; rti = 1; applyStimulus(); rti = 0;
        repeat (8) applyStimulus();
        checkOutput("svc_redrain_delay", 64'(freezeRiseCyc - rtiCyc), 64'd2);
        checkOutput("svc_second_ack", 64'(ackCount), 64'd1);
        checkOutput("svc_second_redirect", 64'(redirCount), 64'd1);
        rti = 1; req = 0; applyStimulus(); rti = 0;
        repeat (2) applyStimulus();

        // Level held 20 cycles, handler returns midway
        $display("[TB] level held");
        clearTally();
        req = 1;
        for (int i = 0; i < 20; i++) begin
            rti = (i == 10);
            applyStimulus();
        end
        rti = 0; req = 0;
        repeat (2) applyStimulus();
        checkOutput("level_ack_count", 64'(ackCount), 64'd1);
        checkOutput("level_drain_count", 64'(freezeRises), 64'd1);

        // Reset in PUSH
        $display("[TB] reset in push");
        clearTally();
        req = 1; applyStimulus();
        applyStimulus();
        applyStimulus();
        rst = 1; req = 0; applyStimulus();
        rst = 0;
        repeat (6) applyStimulus();
        checkOutput("rstpush_we_count", 64'(weCount), 64'd1);
        checkOutput("rstpush_no_vec_rd", 64'(reCount), 64'd0);
        checkOutput("rstpush_no_redirect", 64'(redirCount), 64'd0);

        // Request held high across reset release
        $display("[TB] held across reset");
        clearTally();
        rst = 1; req = 1; repeat (2) applyStimulus();
        rst = 0; repeat (8) applyStimulus();
        checkOutput("rstheld_ack_count", 64'(ackCount), 64'd1);
        rti = 1; req = 0; applyStimulus(); rti = 0;
        repeat (2) applyStimulus();

        // Random traffic
        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 5) == 0) req = ~req;
            busy  = ($urandom_range(0, 2) == 0);
            rti   = ($urandom_range(0, 4) == 0);
            npc   = 8'($urandom);
            sp    = 8'($urandom);
            rdata = 8'($urandom);
            applyStimulus();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_entry_seq.md
# intr_entry_seq

Interrupt-entry sequencer for the 8-bit pipelined RISC core: the writer side of the return-address stack that RET/RTI read back in EX. On an external interrupt it freezes fetch, waits for in-flight branches/returns to drain, pushes the resume PC to the data-memory stack, pulses `intr_ack` so EX saves the flags, fetches the handler address from the vector slot, and redirects the PC. Sits beside the fetch/PC unit and arbitrates the data-memory port during entry.

## Interface
Parameters:
- `VEC_ADDR`, 8'h01, data-memory address of the interrupt vector.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `intr_req`  in  1  external interrupt request, level; sampled every cycle.
- `pipe_busy`  in  1  branch or RET/RTI in flight in EX; entry must not proceed while high.
- `next_pc`  in  8  PC of the next instruction to resume.
- `sp_in`  in  8  current stack pointer.
- `mem_rdata`  in  8  data-memory read data, valid the cycle after `mem_re`.
- `rti_done`  in  1  one-cycle pulse when RTI completes its redirect.
- `freeze`  out  1  stall fetch/PC update.
- `mem_we`  out  1  data-memory write strobe.
- `mem_re`  out  1  data-memory read strobe.
- `mem_addr`  out  8  data-memory address.
- `mem_wdata`  out  8  data-memory write data.
- `sp_we`  out  1  stack-pointer write enable.
- `sp_next`  out  8  new stack-pointer value.
- `intr_ack`  out  1  one-cycle pulse; EX copies flags to preserved set.
- `redirect`  out  1  one-cycle PC load.
- `redirect_pc`  out  8  handler address.
- `in_service`  out  1  handler executing; nesting blocked.

## Operation
- Edge detect: `req_d` holds last `intr_req` (reset 0). Rising edge sets `pending`, in any state. `pending` cleared in PUSH. One-deep: further edges while set are merged.
- States: IDLE, DRAIN, PUSH, VEC_RD, VEC_WAIT, SERVICE. Outputs are Moore-decoded from state (plus registered data).
- IDLE: all strobes 0. If `pending` (registered) → DRAIN.
- DRAIN: `freeze`=1. If `pipe_busy`=0: `ret_pc` <= `next_pc`, → PUSH; else stay.
- PUSH: `freeze`=1, `mem_we`=1, `mem_addr`=`sp_in`, `mem_wdata`=`ret_pc`, `sp_we`=1, `sp_next`=`sp_in`-1 (8-bit, 0x00 wraps to 0xFF), `intr_ack`=1. → VEC_RD.
- VEC_RD: `freeze`=1, `mem_re`=1, `mem_addr`=`VEC_ADDR`. → VEC_WAIT.
- VEC_WAIT: `freeze`=1, `redirect`=1, `redirect_pc`=`mem_rdata`. → SERVICE.
- SERVICE: `in_service`=1, `freeze`=0. Pending requests held, not taken. `rti_done`=1 → IDLE.
- `rti_done` outside SERVICE ignored.
- Inactive outputs: `mem_addr`, `mem_wdata`, `sp_next`, `redirect_pc` drive 0 when their strobe is 0.

## Timing
- Reset: state IDLE, `pending`=0, `req_d`=0, `ret_pc`=0; every output 0 the cycle after reset is sampled. Reset mid-sequence aborts at once; no strobe is issued in the following cycle; the partially pushed stack is not repaired.
- `intr_req` held high across reset release counts as one edge.
- Latency, no drain stall: edge sampled at edge 0 → `pending`=1; DRAIN at cycle 1; PUSH cycle 2; VEC_RD cycle 3; VEC_WAIT/`redirect` cycle 4; SERVICE from cycle 5.
- Each `pipe_busy` cycle in DRAIN adds exactly one cycle; `ret_pc` takes `next_pc` from the releasing cycle.
- SERVICE → IDLE → DRAIN: a request pending at `rti_done` enters DRAIN two cycles after the `rti_done` cycle.
- `intr_ack`, `mem_we`, `sp_we` are each exactly one cycle per entry.

## Test plan
- Basic entry: `sp_in`=0xFF, `next_pc`=0x23, M[0x01]=0x40, `intr_req` 0→1 → PUSH writes M[0xFF]=0x23, `sp_next`=0xFE, `intr_ack` 1 cycle; `mem_re` @0x01; `redirect_pc`=0x40 four cycles after the sampled edge; `in_service`=1 next.
- Drain stall: `pipe_busy` high 3 cycles in DRAIN, `next_pc` 0x10→0x11→0x12→0x13 → PUSH 3 cycles late; writes 0x13; `freeze` high throughout.
- SP wrap: `sp_in`=0x00 → `mem_addr`=0x00, `sp_next`=0xFF.
- Request in service: second edge during SERVICE → no strobes; `rti_done` pulse → IDLE one cycle, then DRAIN and full entry.
- Level held: `intr_req` held high 20 cycles with `rti_done` at cycle 10 → exactly one entry, no second DRAIN.
- Reset in PUSH: `reset`=1 in the PUSH cycle → next cycle IDLE, all outputs 0, `pending`=0; no VEC_RD or `redirect` follows.
